// File: rtl/sram_b_burst_reader.sv
// ---------------------------------------------------------------------------
// sram_b_burst_reader
//   Read-side client for a 1w:1r sram_b bank (CE1/A1/Q1 read port, read data
//   valid one cycle after CE1). Accepts a burst command {addr,len}, issues
//   sequential reads and delivers the returned words as a valid/ready stream
//   with full backpressure. Sustains one word per cycle while the sink is
//   ready.
//
// Ports
//   CLK          in   clock, all logic on posedge
//   rst          in   synchronous reset, active-low
//   start_valid  in   burst command valid
//   start_ready  out  command accepted on valid&ready; high only when idle
//   start_addr   in   [ABITS]    first word address
//   start_len    in   [LEN_BITS] number of words, 0 = empty burst
//   CE1          out  SRAM read enable
//   A1           out  [ABITS]    SRAM read address (holds last value when CE1=0)
//   Q1           in   [DBITS]    SRAM read data, valid the cycle after CE1=1
//   out_valid    out  stream word valid
//   out_ready    in   stream sink ready
//   out_data     out  [DBITS]    stream word
//   out_last     out  final word of the burst (qualified by out_valid)
//   busy         out  high from command accept until the done pulse inclusive
//   done         out  one-cycle pulse after the last handshake / empty burst
// ---------------------------------------------------------------------------
module sram_b_burst_reader #(
    parameter int ABITS    = 14,
    parameter int DBITS    = 8,
    parameter int LEN_BITS = 15
) (
    input  logic                CLK,
    input  logic                rst,
    input  logic                start_valid,
    output logic                start_ready,
    input  logic [ABITS-1:0]    start_addr,
    input  logic [LEN_BITS-1:0] start_len,
    output logic                CE1,
    output logic [ABITS-1:0]    A1,
    input  logic [DBITS-1:0]    Q1,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DBITS-1:0]    out_data,
    output logic                out_last,
    output logic                busy,
    output logic                done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    localparam logic [LEN_BITS:0] MAX_LEN = (LEN_BITS + 1)'(1) << ABITS;

    state_t              state_r;
    state_t              state_nxt_s;
    logic [ABITS-1:0]    addr_r;
    logic [ABITS-1:0]    a1_hold_r;
    logic [LEN_BITS-1:0] rem_r;
    logic                inflight_r;
    logic                inflight_last_r;

    logic [DBITS-1:0]    mem_data_r [2];
    logic                mem_last_r [2];
    logic                wr_ptr_r;
    logic                rd_ptr_r;
    logic [1:0]          count_r;

    logic                accept_s;
    logic                pop_s;
    logic [2:0]          credit_sum_s;
    logic                credit_ok_s;
    logic                issue_s;
    logic                last_issue_s;
    logic                head_last_s;

    assign accept_s     = start_valid && (state_r == S_IDLE);
    assign pop_s        = (count_r != 2'd0) && out_ready;
    // Words already buffered plus the one returning next cycle, minus the one
    // leaving now, must leave room for the read we are about to issue.
    assign credit_sum_s = {1'b0, count_r} + {2'b00, inflight_r} - {2'b00, pop_s};
    assign credit_ok_s  = (credit_sum_s < 3'd2);
    assign issue_s      = (state_r == S_ISSUE) && credit_ok_s;
    assign last_issue_s = issue_s && (rem_r == LEN_BITS'(1));
    assign head_last_s  = mem_last_r[rd_ptr_r];

    assign start_ready  = (state_r == S_IDLE);
    assign busy         = (state_r != S_IDLE);
    assign done         = (state_r == S_FIN);
    assign CE1          = issue_s;
    // While no read is issued the port keeps showing the last issued address.
    assign A1           = issue_s ? addr_r : a1_hold_r;
    assign out_valid    = (count_r != 2'd0);
    assign out_data     = mem_data_r[rd_ptr_r];
    assign out_last     = mem_last_r[rd_ptr_r];

    // Next-state decode for the burst FSM.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s) begin
                    if (start_len == {LEN_BITS{1'b0}}) begin
                        state_nxt_s = S_FIN;
                    end else begin
                        state_nxt_s = S_ISSUE;
                    end
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (last_issue_s) begin
                    state_nxt_s = S_DRAIN;
                end else begin
                    state_nxt_s = S_ISSUE;
                end
            end
            S_DRAIN: begin
                if (pop_s && head_last_s) begin
                    state_nxt_s = S_FIN;
                end else begin
                    state_nxt_s = S_DRAIN;
                end
            end
            S_FIN:   state_nxt_s = S_IDLE;
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // FSM state, read address/count and in-flight tracking.
    always_ff @(posedge CLK) begin
        if (!rst) begin
            state_r         <= S_IDLE;
            addr_r          <= {ABITS{1'b0}};
            a1_hold_r       <= {ABITS{1'b0}};
            rem_r           <= {LEN_BITS{1'b0}};
            inflight_r      <= 1'b0;
            inflight_last_r <= 1'b0;
        end else begin
            state_r         <= state_nxt_s;
            inflight_r      <= issue_s;
            inflight_last_r <= last_issue_s;
            if (accept_s) begin
                addr_r <= start_addr;
                rem_r  <= start_len;
            end else if (issue_s) begin
                addr_r    <= addr_r + ABITS'(1);
                rem_r     <= rem_r - LEN_BITS'(1);
                a1_hold_r <= addr_r;
            end else begin
                addr_r <= addr_r;
                rem_r  <= rem_r;
            end
        end
    end

    // Two-entry output buffer: captures Q1 the cycle after each issued read.
    always_ff @(posedge CLK) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                mem_data_r[i] <= {DBITS{1'b0}};
                mem_last_r[i] <= 1'b0;
            end
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (inflight_r) begin
                mem_data_r[wr_ptr_r] <= Q1;
                mem_last_r[wr_ptr_r] <= inflight_last_r;
                wr_ptr_r             <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            count_r <= count_r + {1'b0, inflight_r} - {1'b0, pop_s};
        end
    end

    // Bursts longer than the address space are undefined.
    len_range_a: assert property (@(posedge CLK) disable iff (!rst)
        (start_valid && start_ready) |-> ({1'b0, start_len} <= MAX_LEN));

endmodule

// File: tb/tb_sram_b_burst_reader.sv
module tb_sram_b_burst_reader;

    logic        CLK = 1'b0;
    logic        rst = 1'b0;
    logic        start_valid = 1'b0;
    logic        start_ready;
    logic [13:0] start_addr = 14'd0;
    logic [14:0] start_len = 15'd0;
    logic        CE1;
    logic [13:0] A1;
    logic [7:0]  Q1;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_data;
    logic        out_last;
    logic        busy;
    logic        done;

    sram_b_burst_reader #(.ABITS(14), .DBITS(8), .LEN_BITS(15)) dut (
        .CLK(CLK), .rst(rst),
        .start_valid(start_valid), .start_ready(start_ready),
        .start_addr(start_addr), .start_len(start_len),
        .CE1(CE1), .A1(A1), .Q1(Q1),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last),
        .busy(busy), .done(done)
    );

    always #5 CLK = ~CLK;

    function automatic logic [7:0] sram_word(input logic [13:0] a);
        return a[7:0] ^ {2'b10, a[13:8]};
    endfunction

    // SRAM read port model: one-cycle read latency
    logic [7:0] q_r = 8'd0;
    always @(posedge CLK) if (CE1) q_r <= sram_word(A1);
    assign Q1 = q_r;

    int n_checks = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp_v, $time);
        end
    endtask

    // stimulus drive variables
    logic        rst_v = 1'b0;
    logic        cmd_valid_v = 1'b0;
    logic [13:0] cmd_addr_v = 14'd0;
    logic [14:0] cmd_len_v = 15'd0;
    int          mode = 0;

    // reference model state
    int          cyc = 0;
    logic        rst_seen_r = 1'b1;
    logic        bm_r = 1'b0;
    logic        done_due_r = 1'b0;
    logic        prev_stall_r = 1'b0;
    logic [7:0]  prev_data = 8'd0;
    logic        prev_last = 1'b0;
    logic [13:0] exp_addr_q[$];
    logic [8:0]  exp_word_q[$];
    int          issued = 0, popped = 0;
    logic [13:0] last_a1_m = 14'd0;
    int          acc_cyc = 0, done_cyc = 0, first_ce_cyc = 0, first_ov_cyc = 0;
    int          hs_first = 0, hs_last = 0, hs_cnt = 0, accept_cnt = 0;
    logic        ce_seen = 1'b0, ov_seen = 1'b0;

    task automatic sample_check();
        logic       accept_s;
        logic       pop_s;
        logic       done_now;
        logic       pop_last_m;
        logic [8:0] w;
        logic [13:0] ea;
        cyc++;
        if (rst_seen_r) begin
            chk("rst_ce1", CE1, 0);
            chk("rst_a1", A1, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_last", out_last, 0);
            chk("rst_out_data", out_data, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_start_ready", start_ready, 1);
            exp_addr_q.delete();
            exp_word_q.delete();
            bm_r = 1'b0; done_due_r = 1'b0; prev_stall_r = 1'b0;
            issued = 0; popped = 0; last_a1_m = 14'd0;
        end else begin
            done_now = done_due_r;
            pop_last_m = 1'b0;
            chk("done", done, done_now);
            chk("busy", busy, bm_r);
            chk("start_ready", start_ready, !bm_r);
            if (done_now) done_cyc = cyc;
            if (prev_stall_r) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_data", out_data, prev_data);
                chk("stall_last", out_last, prev_last);
            end
            pop_s = out_valid && out_ready;
            if (CE1) begin
                if (!ce_seen) begin first_ce_cyc = cyc; ce_seen = 1'b1; end
                if (exp_addr_q.size() == 0) begin
                    chk("ce1_unexpected", CE1, 0);
                end else begin
                    ea = exp_addr_q.pop_front();
                    chk("a1", A1, ea);
                    last_a1_m = ea;
                end
                chk("credit", (issued - popped - int'(pop_s)) < 2, 1);
                issued++;
            end else begin
                chk("a1_hold", A1, last_a1_m);
            end
            if (out_valid && !ov_seen) begin first_ov_cyc = cyc; ov_seen = 1'b1; end
            if (pop_s) begin
                if (exp_word_q.size() == 0) begin
                    chk("out_unexpected", out_valid, 0);
                end else begin
                    w = exp_word_q.pop_front();
                    chk("out_data", out_data, w[7:0]);
                    chk("out_last", out_last, w[8]);
                    pop_last_m = w[8];
                    if (hs_cnt == 0) hs_first = cyc;
                    hs_last = cyc;
                    hs_cnt++;
                    popped++;
                end
            end
            accept_s = start_valid && !bm_r && rst;
            done_due_r = pop_last_m || (accept_s && start_len == 15'd0);
            bm_r = accept_s ? 1'b1 : (done_now ? 1'b0 : bm_r);
            if (accept_s) begin
                for (int i = 0; i < int'(start_len); i++) begin
                    logic [13:0] a;
                    a = start_addr + 14'(i);
                    exp_addr_q.push_back(a);
                    exp_word_q.push_back({(i == int'(start_len) - 1), sram_word(a)});
                end
                acc_cyc = cyc; accept_cnt++;
                ce_seen = 1'b0; ov_seen = 1'b0; hs_cnt = 0;
            end
            prev_stall_r = out_valid && !out_ready;
            prev_data = out_data;
            prev_last = out_last;
        end
        rst_seen_r = !rst;
    endtask

    task automatic step();
        @(negedge CLK);
        rst = rst_v;
        start_valid = cmd_valid_v;
        start_addr = cmd_addr_v;
        start_len = cmd_len_v;
        case (mode)
            0: out_ready = 1'b1;
            1: out_ready = (cyc % 2 == 0);
            2: out_ready = (cyc % 3 == 0);
            default: out_ready = 1'b0;
        endcase
        if (!rst_v) out_ready = 1'b0;
        #1;
        sample_check();
    endtask

    typedef struct {
        logic [13:0] addr;
        logic [14:0] len;
        int          mode;
        logic [13:0] exp_last_a1;
        int          exp_done;   // accept-to-done cycles, 0 = not checked
    } vec_t;

    task automatic run_vec(input vec_t v);
        int acc0;
        int budget;
        mode = v.mode;
        cmd_addr_v = v.addr; cmd_len_v = v.len; cmd_valid_v = 1'b1;
        acc0 = accept_cnt;
        budget = 0;
        while (accept_cnt == acc0 && budget < 50) begin step(); budget++; end
        cmd_valid_v = 1'b0;
        chk("accepted", accept_cnt, acc0 + 1);
        budget = 0;
        while (bm_r && budget < 300) begin step(); budget++; end
        chk("burst_timeout", bm_r, 0);
        step();
        chk("words_delivered", hs_cnt, v.len);
        chk("last_a1", A1, v.exp_last_a1);
        if (v.exp_done > 0) chk("done_latency", done_cyc - acc_cyc, v.exp_done);
        if (v.len > 0) begin
            chk("ce1_latency", first_ce_cyc - acc_cyc, 1);
            chk("out_valid_latency", first_ov_cyc - acc_cyc, 3);
        end
        if (v.mode == 0 && v.len > 0) chk("no_bubbles", hs_last - hs_first, v.len - 1);
    endtask

    vec_t vecs[6];

    initial begin
        int acc0;
        int budget;
        vecs[0] = '{14'h0010, 15'd4, 0, 14'h0013, 7};
        vecs[1] = '{14'h0200, 15'd8, 1, 14'h0207, 0};
        vecs[2] = '{14'h3FFE, 15'd4, 0, 14'h0001, 7};
        vecs[3] = '{14'h0055, 15'd0, 0, 14'h0001, 1};
        vecs[4] = '{14'h1234, 15'd1, 0, 14'h1234, 4};
        vecs[5] = '{14'h0400, 15'd6, 2, 14'h0405, 0};

        rst_v = 1'b0;
        repeat (3) step();
        rst_v = 1'b1;
        repeat (2) step();

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // command held valid through a burst: second one taken exactly once
        mode = 0;
        acc0 = accept_cnt;
        cmd_addr_v = 14'h0020; cmd_len_v = 15'd3; cmd_valid_v = 1'b1;
        budget = 0;
        while (accept_cnt == acc0 && budget < 50) begin step(); budget++; end
        cmd_addr_v = 14'h0030; cmd_len_v = 15'd2;
        budget = 0;
        while (accept_cnt < acc0 + 2 && budget < 100) begin step(); budget++; end
        cmd_valid_v = 1'b0;
        chk("held_second_accept", accept_cnt, acc0 + 2);
        budget = 0;
        while (bm_r && budget < 100) begin step(); budget++; end
        repeat (3) step();
        chk("held_accept_once", accept_cnt, acc0 + 2);
        chk("held_words", hs_cnt, 2);
        chk("held_last_a1", A1, 14'h0031);

        // reset in the middle of a 10-word burst
        mode = 0;
        acc0 = accept_cnt;
        cmd_addr_v = 14'h0100; cmd_len_v = 15'd10; cmd_valid_v = 1'b1;
        budget = 0;
        while (accept_cnt == acc0 && budget < 50) begin step(); budget++; end
        cmd_valid_v = 1'b0;
        budget = 0;
        while (hs_cnt < 3 && budget < 50) begin step(); budget++; end
        chk("pre_reset_words", hs_cnt, 3);
        rst_v = 1'b0;
        repeat (3) step();
        rst_v = 1'b1;
        repeat (6) step();
        run_vec('{14'h0000, 15'd2, 0, 14'h0001, 5});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
